// File: rtl/game_sequencer.sv
// Play controller for the rhythm game: debounces start/pause, runs the
// IDLE/COUNTDOWN/PLAY/PAUSE/DONE sequence and drives timer/score control.
module game_sequencer #(
    parameter int TIMER_W         = 10,
    parameter int CNT_TICKS       = 50000000,
    parameter int COUNTDOWN_STEPS = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               CLOCK50M,
    input  logic               RESET_N,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               write,
    input  logic [TIMER_W-1:0] song_length,
    input  logic [TIMER_W-1:0] game_timer,
    output logic               timer_run,
    output logic               timer_clear,
    output logic               score_clear,
    output logic [2:0]         state,
    output logic [1:0]         countdown,
    output logic               game_over
);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CNT_W = (CNT_TICKS > 1) ? $clog2(CNT_TICKS) : 1;
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CNT_TICKS - 1);
    localparam logic [1:0]       CD_INIT   = 2'(COUNTDOWN_STEPS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Lane 0 = start, lane 1 = pause; both active-low raw buttons.
    logic [1:0]            w_btn_n;
    logic [1:0][1:0]       r_sync;
    logic [1:0]            r_level;
    logic [1:0]            r_press;
    logic [1:0][DB_W-1:0]  r_cnt;

    assign w_btn_n = {pause_btn, start_btn};

    always_ff @(posedge CLOCK50M or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync  <= '1;
            r_level <= '1;
            r_cnt   <= '0;
            r_press <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_sync[b]  <= {r_sync[b][0], w_btn_n[b]};
                r_press[b] <= 1'b0;
                if (r_sync[b][1] == r_level[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == DB_LAST) begin
                    r_cnt[b]   <= '0;
                    r_level[b] <= r_sync[b][1];
                    r_press[b] <= ~r_sync[b][1];
                end else begin
                    r_cnt[b] <= r_cnt[b] + 1'b1;
                end
            end
        end
    end

    logic w_start, w_pause, w_hit;
    assign w_start = r_press[0];
    assign w_pause = r_press[1];
    assign w_hit   = (game_timer >= song_length);

    state_t             r_state;
    logic [CNT_W-1:0]   r_tick;
    logic [1:0]         r_countdown;
    logic               r_timer_run, r_timer_clear, r_score_clear, r_game_over;

    always_ff @(posedge CLOCK50M or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= S_IDLE;
            r_tick        <= '0;
            r_countdown   <= '0;
            r_timer_run   <= 1'b0;
            r_timer_clear <= 1'b0;
            r_score_clear <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_timer_clear <= 1'b0;
            r_score_clear <= 1'b0;
            r_game_over   <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start && !write) begin
                        r_state       <= S_COUNTDOWN;
                        r_countdown   <= CD_INIT;
                        r_tick        <= '0;
                        r_timer_clear <= 1'b1;
                        r_score_clear <= 1'b1;
                    end
                end
                S_COUNTDOWN: begin
                    if (write || w_start) begin
                        r_state     <= S_IDLE;
                        r_countdown <= '0;
                        r_timer_run <= 1'b0;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (r_countdown == 2'd1) begin
                            r_state     <= S_PLAY;
                            r_countdown <= '0;
                            r_timer_run <= 1'b1;
                        end else begin
                            r_countdown <= r_countdown - 2'd1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (write || w_start) begin
                        r_state     <= S_IDLE;
                        r_timer_run <= 1'b0;
                    end else if (w_pause) begin
                        r_state     <= S_PAUSE;
                        r_timer_run <= 1'b0;
                    end else if (w_hit) begin
                        r_state     <= S_DONE;
                        r_timer_run <= 1'b0;
                        r_game_over <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (write || w_start) begin
                        r_state     <= S_IDLE;
                        r_timer_run <= 1'b0;
                    end else if (w_pause) begin
                        r_state     <= S_PLAY;
                        r_timer_run <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_countdown <= '0;
                    r_timer_run <= 1'b0;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign countdown   = r_countdown;
    assign timer_run   = r_timer_run;
    assign timer_clear = r_timer_clear;
    assign score_clear = r_score_clear;
    assign game_over   = r_game_over;
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural model predicts the
// outputs each cycle, a monitor compares them against the DUT.
module tb_game_sequencer;
    localparam int TW = 10;
    localparam int CT = 10;
    localparam int CS = 3;
    localparam int DB = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start_btn = 1'b1;
    logic          pause_btn = 1'b1;
    logic          write     = 1'b0;
    logic [TW-1:0] song_length = 10'd5;
    logic [TW-1:0] game_timer  = '0;
    logic          timer_run, timer_clear, score_clear, game_over;
    logic [2:0]    state;
    logic [1:0]    countdown;

    int   checks = 0;
    int   errors = 0;
    bit   en     = 1'b0;
    bit   m_run  = 1'b0;
    bit   m_tclr = 1'b0;
    logic [8:0] expq[$];
    logic [8:0] obs;

    assign obs = {state, countdown, timer_run, timer_clear, score_clear, game_over};

    always #5 clk = ~clk;

    game_sequencer #(
        .TIMER_W(TW), .CNT_TICKS(CT), .COUNTDOWN_STEPS(CS), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK50M(clk), .RESET_N(rst_n), .start_btn(start_btn), .pause_btn(pause_btn),
        .write(write), .song_length(song_length), .game_timer(game_timer),
        .timer_run(timer_run), .timer_clear(timer_clear), .score_clear(score_clear),
        .state(state), .countdown(countdown), .game_over(game_over)
    );

    // Reference model: a button press is seen once the synchronised level has
    // held a new value for DB samples; the countdown digit is derived from
    // elapsed cycles since COUNTDOWN entry.
    initial begin : model
        bit hist[2][6];
        bit mdb[2];
        bit pend[2];
        bit ev[2];
        bit raw[2];
        bit flip, tclr, go;
        int phase, elapsed, cd;
        forever begin
            @(posedge clk);
            if (!en) begin
                for (int b = 0; b < 2; b++) begin
                    for (int i = 0; i < 6; i++) hist[b][i] = 1'b1;
                    mdb[b] = 1'b1; pend[b] = 1'b0;
                end
                phase = 0; elapsed = 0; m_run = 1'b0; m_tclr = 1'b0;
            end else begin
                raw[0] = start_btn; raw[1] = pause_btn;
                for (int b = 0; b < 2; b++) begin
                    ev[b] = pend[b]; pend[b] = 1'b0;
                    for (int i = 5; i > 0; i--) hist[b][i] = hist[b][i-1];
                    hist[b][0] = raw[b];
                    flip = 1'b1;
                    for (int i = 2; i < 6; i++) if (hist[b][i] == mdb[b]) flip = 1'b0;
                    if (flip) begin
                        mdb[b]  = !mdb[b];
                        pend[b] = !mdb[b];
                    end
                end
                tclr = 1'b0; go = 1'b0;
                case (phase)
                    0, 4: if (ev[0] && !write) begin phase = 1; elapsed = 0; tclr = 1'b1; end
                    1: if (write || ev[0]) phase = 0;
                       else begin
                           elapsed++;
                           if (elapsed == CS * CT) phase = 2;
                       end
                    2: if (write || ev[0]) phase = 0;
                       else if (ev[1]) phase = 3;
                       else if (game_timer >= song_length) begin phase = 4; go = 1'b1; end
                    3: if (write || ev[0]) phase = 0;
                       else if (ev[1]) phase = 2;
                    default: phase = 0;
                endcase
                cd = (phase == 1) ? CS - elapsed / CT : 0;
                expq.push_back({3'(phase), 2'(cd), phase == 2, tclr, tclr, go});
                m_run  = (phase == 2);
                m_tclr = tclr;
            end
        end
    end

    // Stand-in for game_clock: cleared by timer_clear, advances while running.
    initial begin : gclock
        forever begin
            @(negedge clk);
            if (!en || m_tclr)                   game_timer = '0;
            else if (m_run && game_timer != '1)  game_timer = game_timer + 1'b1;
        end
    end

    initial begin : monitor
        logic [8:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                checks++;
                if (obs !== 9'd0) begin
                    errors++;
                    $display("FAIL reset_outputs t=%0t got=%b expected=%b", $time, obs, 9'd0);
                end
            end else if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t got{st,cd,run,tclr,sclr,go}=%b expected=%b",
                             $time, obs, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold);
        if (b == 0) start_btn = 1'b0; else pause_btn = 1'b0;
        idle(hold);
        start_btn = 1'b1;
        pause_btn = 1'b1;
        idle(8);
    endtask

    task automatic do_reset();
        en = 1'b0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(6);
        en = 1'b1;
    endtask

    initial begin : stim
        idle(1);
        do_reset();
        // countdown then play to song end
        song_length = 10'd5;
        press(0, 12);
        idle(30);
        // start then abort back to IDLE, then bouncing start
        press(0, 6);
        press(0, 6);
        for (int i = 0; i < 15; i++) begin
            start_btn = 1'b0; idle(2);
            start_btn = 1'b1; idle(2);
        end
        idle(8);
        // pause in IDLE ignored
        press(1, 8);
        // pause / resume in PLAY
        song_length = 10'd1000;
        press(0, 8);
        idle(30);
        press(1, 8);
        idle(5);
        press(1, 8);
        idle(5);
        // upload aborts play
        write = 1'b1; idle(3); write = 1'b0;
        idle(4);
        // start ignored while uploading
        write = 1'b1;
        press(0, 8);
        write = 1'b0;
        idle(4);
        // zero-length song ends immediately
        song_length = 10'd0;
        press(0, 8);
        idle(40);
        // asynchronous reset during countdown digit 2
        press(0, 8);
        idle(4);
        #2;
        do_reset();
        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 6))
                0: press(0, $urandom_range(6, 10));
                1: press(1, $urandom_range(6, 10));
                2: begin write = 1'b1; idle($urandom_range(1, 3)); write = 1'b0; end
                3: idle($urandom_range(1, 40));
                4: song_length = TW'($urandom_range(0, 40));
                5: begin
                    if ($urandom_range(0, 1) == 0) start_btn = 1'b0; else pause_btn = 1'b0;
                    idle($urandom_range(1, 3));
                    start_btn = 1'b1; pause_btn = 1'b1;
                    idle(4);
                end
                default: begin write = 1'b1; press(0, 8); write = 1'b0; end
            endcase
        end
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
